// File: rtl/memory_game_core.sv
// Memory-pairs game engine: player turns, board cursor, two-card pick, timed reveal,
// match resolution, per-player scores and winner/tie detection.
module memory_game_core #(
  parameter int unsigned COLS        = 4,
  parameter int unsigned ROWS        = 4,
  parameter int unsigned CARD_W      = 4,
  parameter int unsigned PLAYERS     = 2,
  parameter int unsigned SHOW_CYCLES = 50_000_000,
  localparam int unsigned N  = COLS * ROWS,
  localparam int unsigned XW = $clog2(COLS),
  localparam int unsigned YW = $clog2(ROWS),
  localparam int unsigned IW = $clog2(N),
  localparam int unsigned PW = $clog2(PLAYERS),
  localparam int unsigned SW = $clog2(N / 2 + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_select,
  input  logic                    start,
  input  logic                    load_en,
  input  logic [IW-1:0]           load_idx,
  input  logic [CARD_W-1:0]       load_card,
  output logic [XW-1:0]           cursor_x,
  output logic [YW-1:0]           cursor_y,
  output logic [N*CARD_W-1:0]     card_value,
  output logic [N*2-1:0]          card_state,
  output logic [PW-1:0]           cur_player,
  output logic [PLAYERS*SW-1:0]   score,
  output logic                    busy,
  output logic                    game_over,
  output logic [PW-1:0]           winner,
  output logic                    tie
);

  // Reveal timer only needs to reach SHOW_CYCLES-1.
  localparam int unsigned TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  localparam logic [1:0] C_HIDDEN  = 2'b00;
  localparam logic [1:0] C_UP      = 2'b01;
  localparam logic [1:0] C_MATCHED = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK1,
    S_PICK2,
    S_SHOW,
    S_RESOLVE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       cursor_x_q, cursor_x_d;
  logic [YW-1:0]       cursor_y_q, cursor_y_d;
  logic [CARD_W-1:0]   val_q [N];
  logic [CARD_W-1:0]   val_d [N];
  logic [1:0]          cst_q [N];
  logic [1:0]          cst_d [N];
  logic [PW-1:0]       player_q, player_d;
  logic [SW-1:0]       score_q [PLAYERS];
  logic [SW-1:0]       score_d [PLAYERS];
  logic [IW-1:0]       first_q, first_d;
  logic [IW-1:0]       second_q, second_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                busy_q, busy_d;
  logic                game_over_q, game_over_d;

  logic [IW-1:0]       cur_idx_c;
  logic                all_matched_c;
  logic [SW-1:0]       best_c;
  logic [PW-1:0]       win_c;
  logic                tie_c;

  // Linear index of the cell under the cursor.
  assign cur_idx_c = IW'(cursor_y_q) * IW'(COLS) + IW'(cursor_x_q);

  // State register and all game storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cursor_x_q  <= '0;
      cursor_y_q  <= '0;
      player_q    <= '0;
      first_q     <= '0;
      second_q    <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        val_q[i] <= '0;
        cst_q[i] <= C_HIDDEN;
      end
      for (int p = 0; p < int'(PLAYERS); p++) begin
        score_q[p] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cursor_x_q  <= cursor_x_d;
      cursor_y_q  <= cursor_y_d;
      player_q    <= player_d;
      first_q     <= first_d;
      second_q    <= second_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
      val_q       <= val_d;
      cst_q       <= cst_d;
      score_q     <= score_d;
    end
  end

  // Next-state logic: loading, cursor moves, picks, reveal timing and resolution.
  always_comb begin
    state_d       = state_q;
    cursor_x_d    = cursor_x_q;
    cursor_y_d    = cursor_y_q;
    val_d         = val_q;
    cst_d         = cst_q;
    player_d      = player_q;
    score_d       = score_q;
    first_d       = first_q;
    second_d      = second_q;
    timer_d       = timer_q;
    all_matched_c = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          for (int i = 0; i < int'(N); i++) begin
            cst_d[i] = C_HIDDEN;
          end
          for (int p = 0; p < int'(PLAYERS); p++) begin
            score_d[p] = '0;
          end
          player_d   = '0;
          cursor_x_d = '0;
          cursor_y_d = '0;
          state_d    = S_PICK1;
        end else if (load_en && (32'(load_idx) < 32'(N))) begin
          val_d[load_idx] = load_card;
        end
      end

      S_PICK1, S_PICK2: begin
        if (btn_select) begin
          // Only a hidden card can be picked; anything else leaves the turn untouched.
          if (cst_q[cur_idx_c] == C_HIDDEN) begin
            cst_d[cur_idx_c] = C_UP;
            if (state_q == S_PICK1) begin
              first_d = cur_idx_c;
              state_d = S_PICK2;
            end else begin
              second_d = cur_idx_c;
              timer_d  = '0;
              state_d  = S_SHOW;
            end
          end
        end else if (btn_left) begin
          cursor_x_d = (cursor_x_q == '0) ? XW'(COLS - 1) : cursor_x_q - XW'(1);
        end else if (btn_right) begin
          cursor_x_d = (cursor_x_q == XW'(COLS - 1)) ? '0 : cursor_x_q + XW'(1);
        end else if (btn_up) begin
          cursor_y_d = (cursor_y_q == '0) ? YW'(ROWS - 1) : cursor_y_q - YW'(1);
        end else if (btn_down) begin
          cursor_y_d = (cursor_y_q == YW'(ROWS - 1)) ? '0 : cursor_y_q + YW'(1);
        end
      end

      S_SHOW: begin
        if (timer_q == TW'(SHOW_CYCLES - 1)) begin
          state_d = S_RESOLVE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_RESOLVE: begin
        if (val_q[first_q] == val_q[second_q]) begin
          cst_d[first_q]    = C_MATCHED;
          cst_d[second_q]   = C_MATCHED;
          score_d[player_q] = score_q[player_q] + SW'(1);
        end else begin
          cst_d[first_q]  = C_HIDDEN;
          cst_d[second_q] = C_HIDDEN;
          player_d = (player_q == PW'(PLAYERS - 1)) ? '0 : player_q + PW'(1);
        end
        for (int i = 0; i < int'(N); i++) begin
          if (cst_d[i] != C_MATCHED) begin
            all_matched_c = 1'b0;
          end
        end
        state_d = all_matched_c ? S_DONE : S_PICK1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d == S_SHOW) || (state_d == S_RESOLVE);
    game_over_d = (state_d == S_DONE);
  end

  // Highest score, lowest-index holder wins, tie if any other player shares it.
  always_comb begin
    best_c = score_q[0];
    win_c  = '0;
    tie_c  = 1'b0;
    for (int p = 1; p < int'(PLAYERS); p++) begin
      if (score_q[p] > best_c) begin
        best_c = score_q[p];
        win_c  = PW'(p);
      end
    end
    for (int p = 0; p < int'(PLAYERS); p++) begin
      if ((score_q[p] == best_c) && (PW'(p) != win_c)) begin
        tie_c = 1'b1;
      end
    end
  end

  // Flatten per-cell storage onto the renderer buses.
  for (genvar i = 0; i < int'(N); i++) begin : g_cell
    assign card_value[i*CARD_W +: CARD_W] = val_q[i];
    assign card_state[i*2 +: 2]           = cst_q[i];
  end

  // Flatten per-player scores.
  for (genvar p = 0; p < int'(PLAYERS); p++) begin : g_score
    assign score[p*SW +: SW] = score_q[p];
  end

  assign cursor_x   = cursor_x_q;
  assign cursor_y   = cursor_y_q;
  assign cur_player = player_q;
  assign busy       = busy_q;
  assign game_over  = game_over_q;
  assign winner     = game_over_q ? win_c : '0;
  assign tie        = game_over_q & tie_c;

endmodule
